// File: rtl/mem_port_arbiter_if.sv
// Bundles the IFU, LSU and memory-side handshakes of the shared memory port.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_resp_data;
  logic              ifu_resp_err;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_wen;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [STRB_W-1:0] lsu_req_wstrb;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_resp_data;
  logic              lsu_resp_err;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [STRB_W-1:0] mem_req_wstrb;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              mem_resp_err;

  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
  );

  modport master (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one
// outstanding transaction, with a WAIT timeout that forces an error response.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              last_lsu_q, last_lsu_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_wen_q, req_wen_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [STRB_W-1:0] req_wstrb_q, req_wstrb_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              ifu_resp_valid_q, ifu_resp_valid_d;
  logic              lsu_resp_valid_q, lsu_resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic grant_ifu_c, grant_lsu_c, idle_c;

  // On a tie the grant goes to whoever was not served last.
  assign grant_lsu_c = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_lsu_q);
  assign grant_ifu_c = bus.ifu_req_valid && (!bus.lsu_req_valid || last_lsu_q);
  assign idle_c      = (state_q == S_IDLE) && !rst;

  assign bus.ifu_req_ready  = idle_c && grant_ifu_c;
  assign bus.lsu_req_ready  = idle_c && grant_lsu_c;
  assign bus.mem_req_valid  = mem_req_valid_q;
  assign bus.mem_req_addr   = req_addr_q;
  assign bus.mem_req_wen    = req_wen_q;
  assign bus.mem_req_wdata  = req_wdata_q;
  assign bus.mem_req_wstrb  = req_wstrb_q;
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.ifu_resp_data  = resp_data_q;
  assign bus.ifu_resp_err   = resp_err_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.lsu_resp_data  = resp_data_q;
  assign bus.lsu_resp_err   = resp_err_q;

  always_comb begin
    state_d          = state_q;
    last_lsu_d       = last_lsu_q;
    cnt_d            = cnt_q;
    req_addr_d       = req_addr_q;
    req_wen_d        = req_wen_q;
    req_wdata_d      = req_wdata_q;
    req_wstrb_d      = req_wstrb_q;
    mem_req_valid_d  = mem_req_valid_q;
    ifu_resp_valid_d = 1'b0;
    lsu_resp_valid_d = 1'b0;
    resp_data_d      = resp_data_q;
    resp_err_d       = resp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (grant_lsu_c) begin
          req_addr_d      = bus.lsu_req_addr;
          req_wen_d       = bus.lsu_req_wen;
          req_wdata_d     = bus.lsu_req_wdata;
          req_wstrb_d     = bus.lsu_req_wen ? bus.lsu_req_wstrb : STRB_W'(0);
          last_lsu_d      = 1'b1;
          mem_req_valid_d = 1'b1;
          state_d         = S_REQ;
        end else if (grant_ifu_c) begin
          req_addr_d      = bus.ifu_req_addr;
          req_wen_d       = 1'b0;
          req_wdata_d     = DATA_W'(0);
          req_wstrb_d     = STRB_W'(0);
          last_lsu_d      = 1'b0;
          mem_req_valid_d = 1'b1;
          state_d         = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          cnt_d           = CNT_W'(0);
          state_d         = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response in the same cycle as the limit takes priority over timeout.
        if (bus.mem_resp_valid) begin
          resp_err_d       = bus.mem_resp_err;
          resp_data_d      = req_wen_q ? DATA_W'(0) : bus.mem_resp_data;
          ifu_resp_valid_d = !last_lsu_q;
          lsu_resp_valid_d = last_lsu_q;
          state_d          = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_err_d       = 1'b1;
          resp_data_d      = DATA_W'(0);
          ifu_resp_valid_d = !last_lsu_q;
          lsu_resp_valid_d = last_lsu_q;
          state_d          = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      last_lsu_q       <= 1'b1;
      cnt_q            <= '0;
      req_addr_q       <= '0;
      req_wen_q        <= 1'b0;
      req_wdata_q      <= '0;
      req_wstrb_q      <= '0;
      mem_req_valid_q  <= 1'b0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      resp_data_q      <= '0;
      resp_err_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_lsu_q       <= last_lsu_d;
      cnt_q            <= cnt_d;
      req_addr_q       <= req_addr_d;
      req_wen_q        <= req_wen_d;
      req_wdata_q      <= req_wdata_d;
      req_wstrb_q      <= req_wstrb_d;
      mem_req_valid_q  <= mem_req_valid_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      resp_data_q      <= resp_data_d;
      resp_err_q       <= resp_err_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of grant order and response content.
module tb_mem_port_arbiter;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_req_addr   = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_addr   = '0;
    bus.lsu_req_wen    = 1'b0;
    bus.lsu_req_wdata  = '0;
    bus.lsu_req_wstrb  = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.mem_resp_err   = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Memory-side behaviour for one accepted request; entered in the cycle after the
  // accept and returns in the cycle after the response pulse (or after the bound).
  // rsp_dly < 0 means memory never answers.
  task automatic run_mem(input int rdy_dly, input int rsp_dly,
                         input logic [31:0] rdata, input logic rerr,
                         output logic stable, output logic [31:0] a, output logic we,
                         output logic [31:0] wd, output logic [3:0] ws,
                         output int lat, output logic pi, output logic pl,
                         output logic [31:0] d, output logic e, output logic rdy_busy);
    stable = 1'b1; lat = -1; pi = 1'b0; pl = 1'b0; d = '0; e = 1'b0; rdy_busy = 1'b0;
    a = '0; we = 1'b0; wd = '0; ws = '0;
    for (int i = 0; i <= rdy_dly; i++) begin
      bus.mem_req_ready = (i == rdy_dly);
      @(negedge clk);
      if (i == 0) begin
        a = bus.mem_req_addr; we = bus.mem_req_wen;
        wd = bus.mem_req_wdata; ws = bus.mem_req_wstrb;
      end
      if (!bus.mem_req_valid || bus.mem_req_addr !== a || bus.mem_req_wen !== we ||
          bus.mem_req_wdata !== wd || bus.mem_req_wstrb !== ws) stable = 1'b0;
      if (bus.ifu_req_ready || bus.lsu_req_ready) rdy_busy = 1'b1;
      step();
    end
    bus.mem_req_ready = 1'b0;
    for (int w = 0; w < int'(TO) + 6 && lat < 0; w++) begin
      bus.mem_resp_valid = (w == rsp_dly);
      bus.mem_resp_data  = rdata;
      bus.mem_resp_err   = rerr;
      @(negedge clk);
      if (bus.ifu_req_ready || bus.lsu_req_ready) rdy_busy = 1'b1;
      if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
        lat = w; pi = bus.ifu_resp_valid; pl = bus.lsu_resp_valid;
        d = pi ? bus.ifu_resp_data : bus.lsu_resp_data;
        e = pi ? bus.ifu_resp_err : bus.lsu_resp_err;
      end
      step();
    end
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, bus.ifu_resp_valid,
         bus.lsu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_err} !== 7'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000000", {bus.ifu_req_ready,
        bus.lsu_req_ready, bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid,
        bus.ifu_resp_err, bus.lsu_resp_err});
    end
    n_cmp++;
    if ({bus.ifu_resp_data, bus.lsu_resp_data, bus.mem_req_addr} !== 96'h0) begin
      n_bad++; $display("FAIL reset_data: got %h %h %h want 0", bus.ifu_resp_data,
        bus.lsu_resp_data, bus.mem_req_addr);
    end
    do_reset();
  endtask

  task automatic test_ifu_basic();
    logic stable, we, pi, pl, e, rb; logic [31:0] a, wd, d; logic [3:0] ws; int lat;
    do_reset();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h8000_0000;
    @(negedge clk);
    n_cmp++;
    if (bus.ifu_req_ready !== 1'b1 || bus.lsu_req_ready !== 1'b0) begin
      n_bad++; $display("FAIL basic_ready: got ifu=%b lsu=%b want 1 0",
        bus.ifu_req_ready, bus.lsu_req_ready);
    end
    step();
    bus.ifu_req_valid = 1'b0;
    run_mem(0, 0, 32'h0010_0073, 1'b0, stable, a, we, wd, ws, lat, pi, pl, d, e, rb);
    n_cmp++;
    if ({stable, a, we, wd, ws} !== {1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0}) begin
      n_bad++; $display("FAIL basic_req: got st=%b a=%h we=%b wd=%h ws=%h want 1 80000000 0 0 0",
        stable, a, we, wd, ws);
    end
    n_cmp++;
    if (lat !== 1 || pi !== 1'b1 || pl !== 1'b0) begin
      n_bad++; $display("FAIL basic_resp_timing: got lat=%0d ifu=%b lsu=%b want 1 1 0", lat, pi, pl);
    end
    n_cmp++;
    if (d !== 32'h0010_0073 || e !== 1'b0) begin
      n_bad++; $display("FAIL basic_resp_data: got %h err=%b want 00100073 0", d, e);
    end
  endtask

  task automatic test_fairness();
    logic stable, we, pi, pl, e, rb; logic [31:0] a, wd, d; logic [3:0] ws; int lat;
    logic exp_lsu;
    do_reset();
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0004;
    bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_1000;
    bus.lsu_req_wen   = 1'b0; bus.lsu_req_wstrb = 4'hF; bus.lsu_req_wdata = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      exp_lsu = (i % 2) == 1;
      @(negedge clk);
      n_cmp++;
      if (bus.ifu_req_ready !== !exp_lsu || bus.lsu_req_ready !== exp_lsu) begin
        n_bad++; $display("FAIL fair_grant%0d: got ifu=%b lsu=%b want %b %b", i,
          bus.ifu_req_ready, bus.lsu_req_ready, !exp_lsu, exp_lsu);
      end
      step();
      run_mem(0, 1, 32'hC0DE_0000 + 32'(i), 1'b0, stable, a, we, wd, ws, lat, pi, pl, d, e, rb);
      n_cmp++;
      if (pi !== !exp_lsu || pl !== exp_lsu || d !== 32'hC0DE_0000 + 32'(i) || lat !== 2 ||
          a !== (exp_lsu ? 32'h8000_1000 : 32'h8000_0004) || ws !== 4'h0 || rb !== 1'b0) begin
        n_bad++; $display("FAIL fair_resp%0d: got ifu=%b lsu=%b d=%h lat=%0d a=%h ws=%h rb=%b", i,
          pi, pl, d, lat, a, ws, rb);
      end
    end
    drive_idle();
  endtask

  task automatic test_store_stall();
    logic stable, we, pi, pl, e, rb; logic [31:0] a, wd, d; logic [3:0] ws; int lat;
    do_reset();
    bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_1002;
    bus.lsu_req_wen   = 1'b1; bus.lsu_req_wdata = 32'h0000_00AB; bus.lsu_req_wstrb = 4'b0100;
    @(negedge clk);
    step();
    bus.lsu_req_valid = 1'b0;
    bus.lsu_req_addr  = 32'hFFFF_FFFF; bus.lsu_req_wdata = 32'h1111_1111; bus.lsu_req_wstrb = 4'hF;
    run_mem(5, 0, 32'hDEAD_BEEF, 1'b0, stable, a, we, wd, ws, lat, pi, pl, d, e, rb);
    n_cmp++;
    if ({stable, a, we, wd, ws} !== {1'b1, 32'h8000_1002, 1'b1, 32'h0000_00AB, 4'b0100}) begin
      n_bad++; $display("FAIL store_req: got st=%b a=%h we=%b wd=%h ws=%b", stable, a, we, wd, ws);
    end
    n_cmp++;
    if (pl !== 1'b1 || pi !== 1'b0 || d !== 32'h0 || e !== 1'b0 || lat !== 1) begin
      n_bad++; $display("FAIL store_resp: got lsu=%b ifu=%b d=%h err=%b lat=%0d want 1 0 0 0 1",
        pl, pi, d, e, lat);
    end
  endtask

  task automatic test_timeout();
    logic stable, we, pi, pl, e, rb; logic [31:0] a, wd, d; logic [3:0] ws; int lat; int pulses;
    do_reset();
    bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_2000; bus.lsu_req_wen = 1'b0;
    step();
    bus.lsu_req_valid = 1'b0;
    run_mem(0, -1, 32'h0, 1'b0, stable, a, we, wd, ws, lat, pi, pl, d, e, rb);
    n_cmp++;
    if (lat !== int'(TO) || pl !== 1'b1 || pi !== 1'b0 || d !== 32'h0 || e !== 1'b1) begin
      n_bad++; $display("FAIL timeout_resp: got lat=%0d lsu=%b ifu=%b d=%h err=%b want %0d 1 0 0 1",
        lat, pl, pi, d, e, TO);
    end
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h7777_7777;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.ifu_resp_valid || bus.lsu_resp_valid || bus.mem_req_valid) pulses++;
      step();
      bus.mem_resp_valid = 1'b0;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL late_resp: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_reset_in_wait();
    logic stable, we, pi, pl, e, rb; logic [31:0] a, wd, d; logic [3:0] ws; int lat; int pulses;
    do_reset();
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0100;
    step();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    repeat (2) step();
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0200;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, bus.ifu_resp_valid,
         bus.lsu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_err} !== 7'b0 ||
        bus.ifu_resp_data !== 32'h0) begin
      n_bad++; $display("FAIL async_reset: got ctl=%b data=%h want 0", {bus.ifu_req_ready,
        bus.lsu_req_ready, bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid,
        bus.ifu_resp_err, bus.lsu_resp_err}, bus.ifu_resp_data);
    end
    step();
    #1 rst = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hBAD0_BAD0;
    @(negedge clk);
    pulses = (bus.ifu_resp_valid || bus.lsu_resp_valid) ? 1 : 0;
    n_cmp++;
    if (bus.ifu_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_accept: got %b want 1", bus.ifu_req_ready);
    end
    step();
    bus.mem_resp_valid = 1'b0;
    bus.ifu_req_valid  = 1'b0;
    run_mem(0, 0, 32'h0000_0BEE, 1'b0, stable, a, we, wd, ws, lat, pi, pl, d, e, rb);
    n_cmp++;
    if (pulses !== 0 || a !== 32'h8000_0200 || pi !== 1'b1 || d !== 32'h0000_0BEE || lat !== 1) begin
      n_bad++; $display("FAIL post_reset_txn: got stale=%0d a=%h ifu=%b d=%h lat=%0d", pulses, a,
        pi, d, lat);
    end
  endtask

  task automatic test_resp_vs_timeout();
    logic stable, we, pi, pl, e, rb; logic [31:0] a, wd, d; logic [3:0] ws; int lat;
    do_reset();
    bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_3000; bus.lsu_req_wen = 1'b0;
    step();
    bus.lsu_req_valid = 1'b0;
    run_mem(0, int'(TO) - 1, 32'h1234_5678, 1'b0, stable, a, we, wd, ws, lat, pi, pl, d, e, rb);
    n_cmp++;
    if (d !== 32'h1234_5678 || e !== 1'b0 || pl !== 1'b1 || lat !== int'(TO)) begin
      n_bad++; $display("FAIL resp_beats_timeout: got d=%h err=%b lsu=%b lat=%0d want 12345678 0 1 %0d",
        d, e, pl, lat, TO);
    end
  endtask

  task automatic test_random();
    logic stable, we, pi, pl, e, rb; logic [31:0] a, wd, d; logic [3:0] ws; int lat;
    logic model_last_lsu, iv, lv, lwen, g_lsu, rerr;
    logic [31:0] iaddr, laddr, lwdata, rdata, exp_d; logic [3:0] lwstrb;
    int rdy_dly, rsp_dly, exp_lat; logic exp_e;
    do_reset();
    model_last_lsu = 1'b1;
    for (int n = 0; n < 40; n++) begin
      iv = 1'($urandom_range(0, 1)); lv = 1'($urandom_range(0, 1));
      if (!iv && !lv) iv = 1'b1;
      iaddr = $urandom; laddr = $urandom; lwdata = $urandom; lwen = 1'($urandom_range(0, 1));
      lwstrb = 4'($urandom); rdata = $urandom; rerr = ($urandom_range(0, 3) == 0);
      rdy_dly = $urandom_range(0, 3);
      rsp_dly = int'($urandom_range(0, TO + 2)) - 1;
      g_lsu = (lv && !iv) || (lv && iv && !model_last_lsu);
      model_last_lsu = g_lsu;
      bus.ifu_req_valid = iv; bus.ifu_req_addr = iaddr;
      bus.lsu_req_valid = lv; bus.lsu_req_addr = laddr; bus.lsu_req_wen = lwen;
      bus.lsu_req_wdata = lwdata; bus.lsu_req_wstrb = lwstrb;
      @(negedge clk);
      n_cmp++;
      if (bus.lsu_req_ready !== g_lsu || bus.ifu_req_ready !== !g_lsu) begin
        n_bad++; $display("FAIL rnd_grant%0d: got ifu=%b lsu=%b want %b %b", n,
          bus.ifu_req_ready, bus.lsu_req_ready, !g_lsu, g_lsu);
      end
      step();
      bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
      bus.ifu_req_addr = $urandom; bus.lsu_req_addr = $urandom; bus.lsu_req_wdata = $urandom;
      run_mem(rdy_dly, rsp_dly, rdata, rerr, stable, a, we, wd, ws, lat, pi, pl, d, e, rb);
      n_cmp++;
      if (g_lsu ? {stable, a, we, wd, ws} !== {1'b1, laddr, lwen, lwdata, lwen ? lwstrb : 4'h0}
                : {stable, a, we, wd, ws} !== {1'b1, iaddr, 1'b0, 32'h0, 4'h0}) begin
        n_bad++; $display("FAIL rnd_req%0d: got st=%b a=%h we=%b wd=%h ws=%h lsu_owner=%b", n,
          stable, a, we, wd, ws, g_lsu);
      end
      if (rsp_dly >= 0 && rsp_dly <= int'(TO) - 1) begin
        exp_lat = rsp_dly + 1; exp_e = rerr; exp_d = (g_lsu && lwen) ? 32'h0 : rdata;
      end else begin
        exp_lat = int'(TO); exp_e = 1'b1; exp_d = 32'h0;
      end
      n_cmp++;
      if (lat !== exp_lat || pl !== g_lsu || pi !== !g_lsu || d !== exp_d || e !== exp_e ||
          rb !== 1'b0) begin
        n_bad++; $display("FAIL rnd_resp%0d: got lat=%0d ifu=%b lsu=%b d=%h e=%b rb=%b want %0d %b %b %h %b 0",
          n, lat, pi, pl, d, e, rb, exp_lat, !g_lsu, g_lsu, exp_d, exp_e);
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_ifu_basic();
    test_fairness();
    test_store_stall();
    test_timeout();
    test_reset_in_wait();
    test_resp_vs_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
